// File: rtl/sync_pkt_fifo.sv
// Single-clock packet FIFO: speculative writes, commit on last word, FWFT read side.
// Optional SYNC_PKT_FIFO_STATS_EN adds saturating commit/drop counters.
module sync_pkt_fifo #(
   parameter int DSIZE      = 8,
   parameter int ASIZE      = 11,
   parameter int AFULL_LVL  = (1 << ASIZE) - 64,
   parameter int AEMPTY_LVL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr_en,
   input  logic [DSIZE-1:0] i_wr_data,
   input  logic             i_wr_last,
   input  logic             i_wr_drop,
   output logic             o_wfull,
   output logic             o_awfull,
   output logic [ASIZE:0]   o_wr_level,
   output logic             o_drop_pulse,
   input  logic             i_rd_en,
   output logic [DSIZE-1:0] o_rd_data,
   output logic             o_rd_last,
   output logic             o_rempty,
   output logic             o_arempty,
   output logic [ASIZE:0]   o_rd_level,
`ifdef SYNC_PKT_FIFO_STATS_EN
   output logic [31:0]      o_stat_commit,
   output logic [31:0]      o_stat_drop,
`endif
   output logic [ASIZE:0]   o_pkt_cnt
);

   localparam int DEPTH = 1 << ASIZE;
   localparam logic [ASIZE:0] W_DEPTH  = {1'b1, {ASIZE{1'b0}}};
   localparam logic [ASIZE:0] W_AFULL  = (ASIZE+1)'(AFULL_LVL);
   localparam logic [ASIZE:0] W_AEMPTY = (ASIZE+1)'(AEMPTY_LVL);

   logic [DSIZE:0] r_mem [DEPTH];
   logic [ASIZE:0] r_wptr;
   logic [ASIZE:0] r_cptr;
   logic [ASIZE:0] r_rptr;
   logic [ASIZE:0] r_pkt_cnt;
   logic           r_ovf;
   logic           r_drop_pulse;

   logic [ASIZE:0] w_wlevel;
   logic [ASIZE:0] w_rlevel;
   logic [DSIZE:0] w_head;
   logic           w_full;
   logic           w_empty;
   logic           w_wr_ok;
   logic           w_commit;
   logic           w_ovf_word;
   logic           w_drop;
   logic           w_rd_ok;
   logic           w_pop_last;

   assign w_wlevel = r_wptr - r_rptr;
   assign w_rlevel = r_cptr - r_rptr;
   assign w_full   = (w_wlevel == W_DEPTH);
   assign w_empty  = (r_cptr == r_rptr);
   assign w_head   = r_mem[r_rptr[ASIZE-1:0]];

   assign w_wr_ok    = i_wr_en & ~i_wr_drop & ~w_full & ~r_ovf;
   assign w_commit   = w_wr_ok & i_wr_last;
   // Once a frame has lost a word it is poisoned until its last word arrives.
   assign w_ovf_word = i_wr_en & ~i_wr_drop & (w_full | r_ovf);
   assign w_drop     = i_wr_drop | (w_ovf_word & i_wr_last);
   assign w_rd_ok    = i_rd_en & ~w_empty;
   assign w_pop_last = w_rd_ok & w_head[DSIZE];

   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[r_wptr[ASIZE-1:0]] <= {i_wr_last, i_wr_data};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr       <= '0;
         r_cptr       <= '0;
         r_rptr       <= '0;
         r_ovf        <= 1'b0;
         r_drop_pulse <= 1'b0;
      end else begin
         r_drop_pulse <= w_drop;
         if (w_drop) begin
            r_wptr <= r_cptr;
            r_ovf  <= 1'b0;
         end else if (w_wr_ok) begin
            r_wptr <= r_wptr + 1'b1;
            if (i_wr_last) begin
               r_cptr <= r_wptr + 1'b1;
            end
         end else if (w_ovf_word) begin
            r_ovf <= 1'b1;
         end
         if (w_rd_ok) begin
            r_rptr <= r_rptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pkt_cnt <= '0;
      end else begin
         case ({w_commit, w_pop_last})
            2'b10:   r_pkt_cnt <= r_pkt_cnt + 1'b1;
            2'b01:   r_pkt_cnt <= r_pkt_cnt - 1'b1;
            default: r_pkt_cnt <= r_pkt_cnt;
         endcase
      end
   end

`ifdef SYNC_PKT_FIFO_STATS_EN
   logic [31:0] r_stat_commit;
   logic [31:0] r_stat_drop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_commit <= '0;
         r_stat_drop   <= '0;
      end else begin
         if (w_commit && r_stat_commit != 32'hFFFF_FFFF) begin
            r_stat_commit <= r_stat_commit + 32'd1;
         end
         if (w_drop && r_stat_drop != 32'hFFFF_FFFF) begin
            r_stat_drop <= r_stat_drop + 32'd1;
         end
      end
   end

   assign o_stat_commit = r_stat_commit;
   assign o_stat_drop   = r_stat_drop;
`endif

   assign o_wfull      = w_full;
   assign o_awfull     = (w_wlevel >= W_AFULL);
   assign o_wr_level   = w_wlevel;
   assign o_drop_pulse = r_drop_pulse;
   assign o_rd_data    = w_head[DSIZE-1:0];
   assign o_rd_last    = w_head[DSIZE];
   assign o_rempty     = w_empty;
   assign o_arempty    = (w_rlevel <= W_AEMPTY);
   assign o_rd_level   = w_rlevel;
   assign o_pkt_cnt    = r_pkt_cnt;

endmodule

// File: tb/tb_sync_pkt_fifo.sv
// Directed + randomized bench for sync_pkt_fifo (DEPTH 16) against a queue model.
// Model: committed-word queue, pending-frame queue, overflow flag.
module tb_sync_pkt_fifo;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int DEP = 16;
   localparam int AFL = 12;
   localparam int AEL = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_last = 1'b0;
   logic          wr_drop = 1'b0;
   logic          rd_en = 1'b0;
   logic          wfull, awfull, drop_pulse, rd_last, rempty, arempty;
   logic [AW:0]   wr_level, rd_level, pkt_cnt;
   logic [DW-1:0] rd_data;
`ifdef SYNC_PKT_FIFO_STATS_EN
   logic [31:0]   stat_commit, stat_drop;
   int            m_commits = 0;
   int            m_drops = 0;
`endif

   sync_pkt_fifo #(
      .DSIZE(DW), .ASIZE(AW), .AFULL_LVL(AFL), .AEMPTY_LVL(AEL)
   ) dut (
      .clk(clk), .rst(rst),
      .i_wr_en(wr_en), .i_wr_data(wr_data),
      .i_wr_last(wr_last), .i_wr_drop(wr_drop),
      .o_wfull(wfull), .o_awfull(awfull),
      .o_wr_level(wr_level), .o_drop_pulse(drop_pulse),
      .i_rd_en(rd_en), .o_rd_data(rd_data), .o_rd_last(rd_last),
      .o_rempty(rempty), .o_arempty(arempty),
      .o_rd_level(rd_level),
`ifdef SYNC_PKT_FIFO_STATS_EN
      .o_stat_commit(stat_commit), .o_stat_drop(stat_drop),
`endif
      .o_pkt_cnt(pkt_cnt)
   );

   always #5 clk = ~clk;

   logic [DW:0] com[$];
   logic [DW:0] pend[$];
   bit          m_ovf = 0;
   bit          m_drop = 0;
   int          n_pass = 0;
   int          n_total = 0;
   int          max_pkt = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h t=%0t",
                  tag, obs, exp, $time);
   endtask

   function automatic int count_frames();
      int n = 0;
      foreach (com[i]) if (com[i][DW]) n++;
      return n;
   endfunction

   task automatic check_all();
      int tot = com.size() + pend.size();
      int pk = count_frames();
      if (pk > max_pkt) max_pkt = pk;
      chk("rempty", 32'(rempty), 32'(com.size() == 0));
      chk("wfull", 32'(wfull), 32'(tot == DEP));
      chk("awfull", 32'(awfull), 32'(tot >= AFL));
      chk("arempty", 32'(arempty), 32'(com.size() <= AEL));
      chk("wr_level", 32'(wr_level), 32'(tot));
      chk("rd_level", 32'(rd_level), 32'(com.size()));
      chk("pkt_cnt", 32'(pkt_cnt), 32'(pk));
      chk("drop_pulse", 32'(drop_pulse), 32'(m_drop));
      if (com.size() != 0) begin
         chk("rd_data", 32'(rd_data), 32'(com[0][DW-1:0]));
         chk("rd_last", 32'(rd_last), 32'(com[0][DW]));
      end
`ifdef SYNC_PKT_FIFO_STATS_EN
      chk("stat_commit", stat_commit, 32'(m_commits));
      chk("stat_drop", stat_drop, 32'(m_drops));
`endif
   endtask

   task automatic model_reset();
      com.delete();
      pend.delete();
      m_ovf = 0;
      m_drop = 0;
`ifdef SYNC_PKT_FIFO_STATS_EN
      m_commits = 0;
      m_drops = 0;
`endif
   endtask

   task automatic step(input logic we, input logic [DW-1:0] d,
                       input logic l, input logic dr, input logic re);
      bit full = (com.size() + pend.size()) == DEP;
      bit rok = re && (com.size() != 0);
      wr_en = we; wr_data = d; wr_last = l; wr_drop = dr; rd_en = re;
      @(posedge clk);
      #1;
      m_drop = 0;
      if (dr) begin
         pend.delete(); m_ovf = 0; m_drop = 1;
      end else if (we) begin
         if (full || m_ovf) begin
            if (l) begin
               pend.delete(); m_ovf = 0; m_drop = 1;
            end else m_ovf = 1;
         end else begin
            pend.push_back({l, d});
            if (l) begin
               foreach (pend[i]) com.push_back(pend[i]);
               pend.delete();
`ifdef SYNC_PKT_FIFO_STATS_EN
               m_commits++;
`endif
            end
         end
      end
`ifdef SYNC_PKT_FIFO_STATS_EN
      if (m_drop) m_drops++;
`endif
      if (rok) void'(com.pop_front());
      wr_en = 0; wr_last = 0; wr_drop = 0; rd_en = 0;
      check_all();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check_all();
      rst = 1'b0;
      step(0, 0, 0, 0, 0);

      // basic 4-word frame then drain
      for (int i = 0; i < 4; i++) step(1, 8'(8'h11 + i), i == 3, 0, 0);
      chk("rd_data_first", 32'(rd_data), 32'h11);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);

      // explicit drop of a 3-word partial frame, then a clean frame
      for (int i = 0; i < 3; i++) step(1, 8'(8'h30 + i), 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      step(1, 8'h41, 0, 0, 0);
      step(1, 8'h42, 1, 0, 0);
      repeat (2) step(0, 0, 0, 0, 1);

      // 8-word frame then a 10-word frame overflows
      for (int i = 0; i < 8; i++) step(1, 8'(8'h50 + i), i == 7, 0, 0);
      for (int i = 0; i < 10; i++) step(1, 8'(8'h60 + i), i == 9, 0, 0);
      chk("ovf_level", 32'(wr_level), 32'd8);
      for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 1);

      // last word lands exactly on full: dropped at once
      for (int i = 0; i < 15; i++) step(1, 8'(i), 0, 0, 0);
      step(1, 8'hAA, 0, 0, 0);
      step(1, 8'hAB, 1, 0, 0);
      step(1, 8'hAC, 1, 0, 0);
      step(0, 0, 0, 0, 1);

      // commit of frame N+1 alongside rd_last pop of frame N
      step(1, 8'h71, 1, 0, 0);
      step(1, 8'h72, 0, 0, 0);
      step(1, 8'h73, 1, 0, 1);
      chk("pkt_same_cycle", 32'(pkt_cnt), 32'd1);
      repeat (3) step(0, 0, 0, 0, 1);

      // wrap-around streaming of single-word frames
      for (int i = 0; i < 40; i++)
         step(1, 8'(8'h80 + i), 1, 0, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 20 && com.size() != 0; i++) step(0, 0, 0, 0, 1);

      // randomized mixed traffic
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 3) != 0), 8'($urandom),
              1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 24) == 0),
              1'($urandom_range(0, 1)));
      chk("pkt_max", 32'(max_pkt <= DEP), 32'd1);

      // async reset in the middle of a frame with a committed frame present
      step(1, 8'h91, 1, 0, 0);
      step(1, 8'h92, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sync_pkt_fifo.md
Name: sync_pkt_fifo

Overview:
- Single-clock, parametrised packet FIFO for the Ethernet datapath. It succeeds the dual-clock word FIFO for same-domain buffering.
- Writes are speculative until the frame's last word commits them. A frame can be discarded mid-write (e.g. bad FCS), and a frame that overflows is dropped automatically.
- The read side sees only committed frames, first-word fall-through, with a frame-end marker and committed-frame count.

Parameters:
- DSIZE, 8, data width in bits.
- ASIZE, 11, address width; DEPTH = 2**ASIZE words.
- AFULL_LVL, DEPTH-64, awfull asserts when wr_level >= AFULL_LVL.
- AEMPTY_LVL, 1, arempty asserts when rd_level <= AEMPTY_LVL.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write word this cycle.
- wr_data  in  DSIZE  write data.
- wr_last  in  1  qualifies wr_en; this word ends the frame.
- wr_drop  in  1  discard the current uncommitted frame.
- wfull  out  1  wr_level == DEPTH.
- awfull  out  1  almost full.
- wr_level  out  ASIZE+1  words held, including uncommitted (wptr - rptr).
- drop_pulse  out  1  one-cycle pulse when a frame is discarded (explicit or overflow).
- rd_en  in  1  pop head word.
- rd_data  out  DSIZE  head word, valid while !rempty.
- rd_last  out  1  head word is a frame end.
- rempty  out  1  no committed word (rptr == cptr).
- arempty  out  1  almost empty.
- rd_level  out  ASIZE+1  committed words (cptr - rptr).
- pkt_cnt  out  ASIZE+1  complete committed frames not yet fully read.

Behaviour:
- Storage: DEPTH x (DSIZE+1) array holding data and the last flag. rd_data/rd_last are read combinationally at raddr (FWFT, zero latency).
- Pointers: wptr (speculative), cptr (committed), rptr. All are ASIZE+1-bit binary; the MSB disambiguates full from empty. Wrap is natural modulo 2**(ASIZE+1).
- Reset: all pointers, pkt_cnt and the ovf flag clear. Resulting outputs:
  - rempty=1, arempty=1, wfull=0, awfull=0.
  - wr_level=0, rd_level=0, pkt_cnt=0, drop_pulse=0.
  - rd_data/rd_last are don't-care while empty.
  - Reset mid-frame discards everything, including committed frames.
- Flags and levels are combinational from registered pointers. They update in the cycle after the causing edge.
- Write, accepted when wr_en & !wr_drop & !wfull & !ovf:
  - mem[wptr] <= {wr_last, wr_data}; wptr++.
  - If wr_last: cptr <= wptr+1 and the frame becomes visible to the read side next cycle.
- Overflow, when wr_en & wfull & !wr_drop:
  - The word is not written and ovf <= 1.
  - While ovf=1, further words are discarded. If that word has wr_last: wptr <= cptr, ovf <= 0, drop_pulse = 1.
  - If wr_last and wfull occur on the same word, the frame is dropped that cycle (no ovf hold).
- wr_drop (any cycle, with or without wr_en): wptr <= cptr, ovf <= 0, drop_pulse = 1. It takes priority over a simultaneous write/commit, so that word is discarded.
- wr_drop with no uncommitted words (wptr == cptr) still pulses drop_pulse with no state change.
- Read, accepted when rd_en & !rempty: rptr++. rd_en while empty is ignored, with no error.
- pkt_cnt: +1 on commit, -1 on accepted read with rd_last. Simultaneous commit and read-last leaves it unchanged.
- Simultaneous read and write both proceed. With rd_en while wfull, the write is still refused that cycle because wfull is registered-pointer based.
- A frame longer than DEPTH always ends in overflow drop.

Optional Feature:
- Macro SYNC_PKT_FIFO_STATS_EN. When defined, adds outputs stat_commit and stat_drop, each 32 bits:
  - stat_commit increments on each commit; stat_drop increments on each drop_pulse.
  - Both saturate at 0xFFFFFFFF and clear on rst.
- When undefined, these ports and their counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset, then write a 4-word frame 0x11..0x14 with wr_last on 0x14:
  - rempty stays 1 through the 4th write edge and deasserts the following cycle.
  - Then pkt_cnt=1, rd_level=4, rd_data=0x11.
  - Popping 4 words yields 0x11..0x14 with rd_last only on 0x14; ends with pkt_cnt=0, rempty=1.
- Write 3 words, assert wr_drop:
  - drop_pulse for 1 cycle, wr_level back to 0, rempty never deasserts.
  - A following 2-word frame reads back intact.
- ASIZE=4 (DEPTH 16): commit an 8-word frame, then write a 10-word frame without reading.
  - wfull at wr_level=16 and the 9th word is refused.
  - At wr_last: drop_pulse, wr_level=8, pkt_cnt=1, and the first frame reads intact.
- Wrap-around: ASIZE=4, stream 40 single-word frames with concurrent reads.
  - Data sequence is preserved and pkt_cnt never exceeds 16.
  - awfull/arempty track AFULL_LVL/AEMPTY_LVL exactly.
- Same-cycle commit of frame N+1 and rd_last pop of frame N leaves pkt_cnt unchanged.
- Assert rst mid-write with a committed frame present: all outputs return to reset values immediately (async). With STATS_EN, both stat counters read 0.
